// File: rtl/intra_block_fetcher.sv
// Intra front-end fetcher: walks the frame in 4x4 luma blocks (raster order),
// reads four packed 2x2 words per block, and presents the assembled block with
// its top/left neighbour samples over a valid/ready handshake.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no frame in progress; waits for start
//   REQ    | one-cycle read strobe for the current 2x2 sub-block
//   WAIT   | read latency down-count; captures mem_rdata on terminal count
//   OUT    | block presented, held stable until blk_ready
module intra_block_fetcher #(
  parameter int FRAME_W_BLK = 106,
  parameter int FRAME_H_BLK = 60,
  parameter int ADDR_W      = 15,
  parameter int MEM_LAT     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  output logic [127:0]      blk_pixels,
  output logic [31:0]       top_nbr,
  output logic [31:0]       left_nbr,
  output logic              top_avail,
  output logic              left_avail,
  output logic [6:0]        blk_x,
  output logic [5:0]        blk_y,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam int IDX_W            = (FRAME_W_BLK > 1) ? $clog2(FRAME_W_BLK) : 1;
  localparam int ROW_WORDS        = 2 * FRAME_W_BLK;
  localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

  state_t        state, state_nxt;
  logic [6:0]    bx;
  logic [5:0]    by;
  logic [1:0]    sub;
  logic [1:0]    lat_cnt;
  logic [127:0]  blk_reg;
  logic [31:0]   col_cache;
  logic [31:0]   row_cache [FRAME_W_BLK];
  logic          xfer, cap, last_bx, last_by;

  assign last_bx = (bx == 7'(FRAME_W_BLK - 1));
  assign last_by = (by == 6'(FRAME_H_BLK - 1));
  assign xfer    = (state == S_OUT) && blk_ready;
  assign cap     = (state == S_WAIT) && (lat_cnt == 2'd0);

  // State register; reset wins over everything and parks the FSM in IDLE.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode plus the read strobe/address for the current sub-block.
  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    case (state)
      S_IDLE: if (start) state_nxt = S_REQ;
      S_REQ: begin
        mem_rd    = 1'b1;
        mem_addr  = ADDR_W'({by, sub[1]}) * ADDR_W'(ROW_WORDS) + ADDR_W'({bx, sub[0]});
        state_nxt = S_WAIT;
      end
      S_WAIT: if (cap) state_nxt = (sub == 2'd3) ? S_OUT : S_REQ;
      S_OUT:  if (blk_ready) state_nxt = (last_bx && last_by) ? S_IDLE : S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Indices, latency timer, block assembly, column cache and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      bx         <= '0;
      by         <= '0;
      sub        <= '0;
      lat_cnt    <= '0;
      blk_reg    <= '0;
      col_cache  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= xfer && last_bx && last_by;
      if (state == S_IDLE && start) begin
        bx  <= '0;
        by  <= '0;
        sub <= '0;
      end
      if (state == S_REQ)                          lat_cnt <= LAT_LOAD;
      else if (state == S_WAIT && lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;
      if (cap) begin
        // Sub-block (sx,sy) covers pixels (2sy..2sy+1, 2sx..2sx+1); bit 2 of
        // the pixel index selects the lower row, bit 0 the right column.
        blk_reg[{sub[1], 1'b0, sub[0], 1'b0, 3'b000} +: 8] <= mem_rdata[7:0];
        blk_reg[{sub[1], 1'b0, sub[0], 1'b1, 3'b000} +: 8] <= mem_rdata[15:8];
        blk_reg[{sub[1], 1'b1, sub[0], 1'b0, 3'b000} +: 8] <= mem_rdata[23:16];
        blk_reg[{sub[1], 1'b1, sub[0], 1'b1, 3'b000} +: 8] <= mem_rdata[31:24];
        sub <= sub + 2'd1;
      end
      if (xfer) begin
        col_cache <= {blk_reg[127:120], blk_reg[95:88], blk_reg[63:56], blk_reg[31:24]};
        if (last_bx) begin
          bx <= '0;
          by <= last_by ? 6'd0 : by + 6'd1;
        end else begin
          bx <= bx + 7'd1;
        end
      end
    end
  end

  // Bottom-row cache per block column; contents are masked by top_avail.
  always_ff @(posedge clk) begin
    if (!reset && xfer) row_cache[bx[IDX_W-1:0]] <= blk_reg[127:96];
  end

  assign top_avail  = (by != 6'd0);
  assign left_avail = (bx != 7'd0);
  assign top_nbr    = top_avail  ? row_cache[bx[IDX_W-1:0]] : 32'd0;
  assign left_nbr   = left_avail ? col_cache : 32'd0;
  assign blk_pixels = blk_reg;
  assign blk_x      = bx;
  assign blk_y      = by;
  assign blk_valid  = (state == S_OUT);
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_intra_block_fetcher.sv
// Directed bench: a 2x2-block frame fetched by a MEM_LAT=1 instance (A) and a
// MEM_LAT=3 instance (B); memory word[a] = {4{a[7:0]}}.
module tb_intra_block_fetcher;
  localparam int AW = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, blk_ready, sel;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  logic reset_a, start_a, ready_a, mem_rd_a, top_avail_a, left_avail_a, blk_valid_a, busy_a, frame_done_a;
  logic [AW-1:0] mem_addr_a;
  logic [31:0]   mem_rdata_a, top_nbr_a, left_nbr_a;
  logic [127:0]  blk_pixels_a;
  logic [6:0]    blk_x_a;
  logic [5:0]    blk_y_a;

  logic reset_b, start_b, ready_b, mem_rd_b, top_avail_b, left_avail_b, blk_valid_b, busy_b, frame_done_b;
  logic [AW-1:0] mem_addr_b;
  logic [31:0]   mem_rdata_b, top_nbr_b, left_nbr_b;
  logic [127:0]  blk_pixels_b;
  logic [6:0]    blk_x_b;
  logic [5:0]    blk_y_b;

  // Instance not under test is held in reset.
  assign reset_a = sel ? 1'b1 : rst;
  assign reset_b = sel ? rst : 1'b1;
  assign start_a = !sel && start;
  assign start_b = sel && start;
  assign ready_a = !sel && blk_ready;
  assign ready_b = sel && blk_ready;

  intra_block_fetcher #(.FRAME_W_BLK(2), .FRAME_H_BLK(2), .ADDR_W(AW), .MEM_LAT(1)) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .mem_addr(mem_addr_a), .mem_rd(mem_rd_a),
    .mem_rdata(mem_rdata_a), .blk_pixels(blk_pixels_a), .top_nbr(top_nbr_a), .left_nbr(left_nbr_a),
    .top_avail(top_avail_a), .left_avail(left_avail_a), .blk_x(blk_x_a), .blk_y(blk_y_a),
    .blk_valid(blk_valid_a), .blk_ready(ready_a), .busy(busy_a), .frame_done(frame_done_a));

  intra_block_fetcher #(.FRAME_W_BLK(2), .FRAME_H_BLK(2), .ADDR_W(AW), .MEM_LAT(3)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .mem_addr(mem_addr_b), .mem_rd(mem_rd_b),
    .mem_rdata(mem_rdata_b), .blk_pixels(blk_pixels_b), .top_nbr(top_nbr_b), .left_nbr(left_nbr_b),
    .top_avail(top_avail_b), .left_avail(left_avail_b), .blk_x(blk_x_b), .blk_y(blk_y_b),
    .blk_valid(blk_valid_b), .blk_ready(ready_b), .busy(busy_b), .frame_done(frame_done_b));

  // Memory models: data is only valid exactly MEM_LAT cycles after mem_rd.
  logic          va = 1'b0;
  logic [AW-1:0] pa = '0;
  always @(posedge clk) begin
    va <= mem_rd_a;
    pa <= mem_addr_a;
  end
  assign mem_rdata_a = va ? {4{pa[7:0]}} : 32'hDEADBEEF;

  logic [2:0]    vb = 3'b000;
  logic [AW-1:0] pb0 = '0, pb1 = '0, pb2 = '0;
  always @(posedge clk) begin
    vb  <= {vb[1:0], mem_rd_b};
    pb0 <= mem_addr_b;
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign mem_rdata_b = vb[2] ? {4{pb2[7:0]}} : 32'hDEADBEEF;

  logic o_mem_rd, o_top_avail, o_left_avail, o_blk_valid, o_busy, o_frame_done;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_top_nbr, o_left_nbr;
  logic [127:0]  o_blk_pixels;
  logic [6:0]    o_blk_x;
  logic [5:0]    o_blk_y;

  always_comb begin
    o_mem_rd     = sel ? mem_rd_b     : mem_rd_a;
    o_mem_addr   = sel ? mem_addr_b   : mem_addr_a;
    o_top_avail  = sel ? top_avail_b  : top_avail_a;
    o_left_avail = sel ? left_avail_b : left_avail_a;
    o_top_nbr    = sel ? top_nbr_b    : top_nbr_a;
    o_left_nbr   = sel ? left_nbr_b   : left_nbr_a;
    o_blk_pixels = sel ? blk_pixels_b : blk_pixels_a;
    o_blk_x      = sel ? blk_x_b      : blk_x_a;
    o_blk_y      = sel ? blk_y_b      : blk_y_a;
    o_blk_valid  = sel ? blk_valid_b  : blk_valid_a;
    o_busy       = sel ? busy_b       : busy_a;
    o_frame_done = sel ? frame_done_b : frame_done_a;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes = passes + 1;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pixel (r,c) of a block whose first word is 'base' in a 2-block-wide frame.
  function automatic logic [127:0] exp_blk(input int base);
    logic [127:0] v;
    v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        v[(r*4+c)*8 +: 8] = 8'(base + (r/2)*4 + c/2);
    return v;
  endfunction

  // Called in the first REQ cycle of a block; ends in the first OUT cycle.
  task automatic fetch(input int lat, input int base, input string tag);
    logic [AW-1:0] got [4];
    int   n;
    logic early;
    n = 0;
    early = 1'b0;
    for (int i = 0; i < 4*(lat+1); i++) begin
      if (o_mem_rd) begin
        if (n < 4) got[n] = o_mem_addr;
        n++;
      end
      if (o_blk_valid) early = 1'b1;
      tick();
    end
    chk({tag, " early_valid"}, 128'(early), 128'(0));
    chk({tag, " valid_at_latency"}, 128'(o_blk_valid), 128'(1));
    chk({tag, " rd_count"}, 128'(n), 128'(4));
    for (int s = 0; s < 4; s++)
      chk({tag, " addr"}, 128'(got[s]), 128'(base + (s/2)*4 + s%2));
    chk({tag, " pixels"}, o_blk_pixels, exp_blk(base));
  endtask

  task automatic accept();
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " ctl"}, 128'({o_mem_addr, o_mem_rd, o_blk_valid, o_busy, o_frame_done,
                            o_top_avail, o_left_avail, o_blk_x, o_blk_y}), 128'(0));
    chk({tag, " pixels"}, o_blk_pixels, 128'(0));
    chk({tag, " nbrs"}, 128'({o_top_nbr, o_left_nbr}), 128'(0));
  endtask

  initial begin
    logic [127:0] snap;
    logic ok;
    sel = 1'b0; rst = 1'b1; start = 1'b0; blk_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_reset("reset");

    // Block (0,0)
    start = 1'b1; tick(); start = 1'b0;
    fetch(1, 0, "b00");
    chk("b00 pix00", 128'(o_blk_pixels[7:0]), 128'(8'h00));
    chk("b00 pix33", 128'(o_blk_pixels[127:120]), 128'(8'h05));
    chk("b00 avail", 128'({o_top_avail, o_left_avail}), 128'(0));
    chk("b00 nbrs", 128'({o_top_nbr, o_left_nbr}), 128'(0));
    chk("b00 xy", 128'({o_blk_x, o_blk_y}), 128'(0));
    chk("b00 busy", 128'(o_busy), 128'(1));

    // Backpressure, with a start pulse while busy that must be ignored
    snap = o_blk_pixels;
    ok = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      start = 1'b0;
      if (o_blk_valid !== 1'b1 || o_blk_pixels !== snap || o_mem_rd !== 1'b0 ||
          o_blk_x !== 7'd0 || o_blk_y !== 6'd0) ok = 1'b0;
    end
    chk("backpressure stable", 128'(ok), 128'(1));
    accept();
    chk("xfer valid_drop", 128'(o_blk_valid), 128'(0));
    chk("xfer next_req", 128'({o_mem_rd, o_mem_addr}), 128'({1'b1, 15'd2}));

    // Block (1,0)
    fetch(1, 2, "b10");
    chk("b10 xy", 128'({o_blk_x, o_blk_y}), 128'({7'd1, 6'd0}));
    chk("b10 avail", 128'({o_top_avail, o_left_avail}), 128'(2'b01));
    chk("b10 left_nbr", 128'(o_left_nbr), 128'(32'h05050101));
    chk("b10 top_nbr", 128'(o_top_nbr), 128'(0));
    accept();

    // Block (0,1)
    fetch(1, 8, "b01");
    chk("b01 xy", 128'({o_blk_x, o_blk_y}), 128'({7'd0, 6'd1}));
    chk("b01 avail", 128'({o_top_avail, o_left_avail}), 128'(2'b10));
    chk("b01 top_nbr", 128'(o_top_nbr), 128'(32'h05050404));
    chk("b01 left_nbr", 128'(o_left_nbr), 128'(0));
    accept();

    // Block (1,1)
    fetch(1, 10, "b11");
    chk("b11 xy", 128'({o_blk_x, o_blk_y}), 128'({7'd1, 6'd1}));
    chk("b11 avail", 128'({o_top_avail, o_left_avail}), 128'(2'b11));
    chk("b11 top_nbr", 128'(o_top_nbr), 128'(32'h07070606));
    chk("b11 left_nbr", 128'(o_left_nbr), 128'(32'h0D0D0909));
    accept();
    chk("done pulse", 128'({o_frame_done, o_busy, o_blk_valid}), 128'(3'b100));
    tick();
    chk("done single", 128'({o_frame_done, o_busy, o_mem_rd}), 128'(0));

    // Reset during WAIT of the second block
    start = 1'b1; tick(); start = 1'b0;
    fetch(1, 0, "r00");
    accept();
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset("midframe reset");
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (o_mem_rd !== 1'b0 || o_busy !== 1'b0) ok = 1'b0;
    end
    chk("stay idle", 128'(ok), 128'(1));
    start = 1'b1; tick(); start = 1'b0;
    fetch(1, 0, "restart");

    // MEM_LAT = 3 instance
    sel = 1'b1; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_reset("lat3 reset");
    start = 1'b1; tick(); start = 1'b0;
    fetch(3, 0, "lat3 b00");
    accept();
    fetch(3, 2, "lat3 b10");
    chk("lat3 b10 left_nbr", 128'(o_left_nbr), 128'(32'h05050101));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
